// File: rtl/lsu_ctrl.sv
// Load/store controller between the execute stage and the data-memory port.
// Checks alignment, builds byte strobes and lane data, runs the request/ack handshake and extends load data.
module lsu_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_strobe,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misalign,
   output logic        resp_timeout,
   output logic        stall
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        we_q;
   logic [7:0]  wait_cnt;

   logic        accept;
   logic        req_fault;
   logic        timeout_hit;
   logic [3:0]  strobe_d;
   logic [31:0] wdata_d;
   logic [31:0] load_ext;

   assign accept      = req_valid && (state_q == IDLE);
   assign timeout_hit = (state_q == BUSY) && !mem_ack && (wait_cnt == WAIT_LAST);

   assign req_ready  = (state_q == IDLE);
   assign stall      = (state_q != IDLE);
   assign mem_req    = (state_q == BUSY);
   assign mem_we     = mem_req && we_q;
   assign resp_valid = (state_q == RESP);

   // Request decode feeds registers only, so no req_* -> mem_* combinational path exists.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      req_fault = 1'b0;
      strobe_d  = 4'b0000;
      wdata_d   = req_wdata;
      unique case (req_size)
         SIZE_BYTE: begin
            strobe_d = 4'b0001 << req_addr[1:0];
            wdata_d  = {4{req_wdata[7:0]}};
         end
         SIZE_HALF: begin
            req_fault = req_addr[0];
            strobe_d  = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_d   = {2{req_wdata[15:0]}};
         end
         SIZE_WORD: begin
            req_fault = (req_addr[1:0] != 2'b00);
            strobe_d  = 4'b1111;
         end
         default: req_fault = 1'b1;
      endcase
   end

   always_comb begin
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      byte_sel = mem_rdata[8*lane_q +: 8];
      half_sel = mem_rdata[16*lane_q[1] +: 16];
      load_ext = mem_rdata;
      if (size_q == SIZE_BYTE)
         load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      else if (size_q == SIZE_HALF)
         load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (req_valid) state_d = req_fault ? RESP : BUSY;
         BUSY: if (mem_ack || timeout_hit) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane_q     <= 2'b00;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         we_q       <= 1'b0;
         mem_addr   <= '0;
         mem_strobe <= '0;
         mem_wdata  <= '0;
         wait_cnt   <= '0;
      end else if (accept) begin
         lane_q     <= req_addr[1:0];
         size_q     <= req_size;
         uns_q      <= req_unsigned;
         we_q       <= req_write;
         mem_addr   <= {req_addr[31:2], 2'b00};
         mem_strobe <= strobe_d;
         mem_wdata  <= wdata_d;
         wait_cnt   <= '0;
      end else if (state_q == BUSY && !mem_ack) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Response fields are loaded on the edge into RESP and cleared on the edge out of it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_rdata    <= '0;
         resp_misalign <= 1'b0;
         resp_timeout  <= 1'b0;
      end else if (state_q == RESP) begin
         resp_rdata    <= '0;
         resp_misalign <= 1'b0;
         resp_timeout  <= 1'b0;
      end else if (accept && req_fault) begin
         resp_misalign <= 1'b1;
      end else if (state_q == BUSY && mem_ack) begin
         resp_rdata <= we_q ? 32'h0 : load_ext;
      end else if (timeout_hit) begin
         resp_timeout <= 1'b1;
      end
   end

endmodule
